spi_slave_regfile: RTL
======================

SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits; legal 8..32.
REQ-002 Parameter DEPTH, default 32, register count; legal 2..256.
REQ-003 Parameter CPOL, default 0, SCLK idle level.
REQ-004 Parameter CPHA, default 0, SPI clock phase.
REQ-005 clk  in  1  system clock; SCLK frequency SHALL be at most clk/8.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 spi_sclk_in  in  1  SPI clock, asynchronous to clk.
REQ-008 spi_cs_n_in  in  1  chip select, active-low, asynchronous to clk.
REQ-009 spi_mosi_in  in  1  master-to-slave data, MSB first.
REQ-010 spi_miso_out  out  1  slave-to-master data, MSB first.
REQ-011 spi_miso_oe  out  1  MISO drive enable; high while the synchronised CS is active.
REQ-012 loc_addr  in  8  local read address.
REQ-013 loc_rdata  out  DATA_W  registered local read data.
REQ-014 wr_valid  out  1  one-cycle pulse per committed SPI write.
REQ-015 wr_addr  out  8  address of the committed write.
REQ-016 wr_data  out  DATA_W  data of the committed write.
REQ-017 busy  out  1  high while a frame is in progress.

Function
REQ-018 The block SHALL synchronise sclk, cs_n and mosi with 2-flop synchronisers and detect SCLK edges from the synchronised signals.
- Sample edge: rising when CPOL==CPHA, falling otherwise.
REQ-019 A frame SHALL begin on the synchronised CS falling edge, which clears the bit counter, shifter and burst state.
REQ-020 Frame format:
- 16-bit command word, then one or more DATA_W-bit data words.
- Command bits: [10:3] address, [2] burst, [1] read=1/write=0; bits [15:11] and [0] ignored.
REQ-021 The FSM SHALL have states IDLE, CMD, DATA.
- IDLE->CMD on CS assert.
- CMD->DATA on the 16th sample edge.
- DATA->DATA at each word boundary only if burst=1; otherwise remain in DATA and ignore further bits.
- Any state->IDLE on CS deassert.
REQ-022 Write word:
- Committed on the DATA_W-th data sample edge.
- wr_valid pulses within 2 clk of that edge; mem[addr] updates in the same cycle as the wr_valid pulse.
REQ-023 Read word:
- mem[addr] is loaded into the output shifter within 2 clk of the last command sample edge (or of the last sample edge of the previous burst word).
- spi_miso_out = shifter MSB; the shifter shifts left within 2 clk after each data sample edge.
REQ-024 Burst SHALL increment the address after each word; the address wraps from DEPTH-1 to 0.
REQ-025 Address >= DEPTH:
- A write is ignored: no wr_valid, no memory change.
- A read returns all zeros.
REQ-026 CS deassert mid-word SHALL discard the partial word: no commit, no wr_valid.
REQ-027 spi_miso_out SHALL be 0 outside the DATA state of a read frame.
REQ-028 loc_rdata SHALL equal mem[loc_addr] one clk after loc_addr is presented, or 0 if loc_addr >= DEPTH.
- If a local read and an SPI write target the same address in the same cycle, the old value is returned.
REQ-029 busy SHALL be high from the synchronised CS assert until the synchronised CS deassert.

Reset
REQ-030 On rst:
- FSM to IDLE; counters, shifters and synchronisers cleared.
- All memory words cleared to 0.
- spi_miso_out, spi_miso_oe, wr_valid, busy, wr_addr, wr_data and loc_rdata all 0.
REQ-031 Reset mid-frame SHALL abort the frame; the remaining SCLK edges are ignored until a new CS falling edge.

Structure
REQ-032 The shared package spi_pkg SHALL hold:
- command width (16);
- command field bit positions: address, burst, read;
- the sample-edge mode function of CPOL/CPHA.
REQ-033 The synchroniser and edge detector SHALL be sub-module spi_sync_edge, instantiated once per asynchronous input.
REQ-034 The memory SHALL be a flop array of DEPTH x DATA_W.

Verification (DATA_W=16, DEPTH=32, clk=100 MHz, SCLK=10 MHz)
REQ-035 Mode 0, cmd 0x00D0 + data 0xBEEF -> single wr_valid with wr_addr=0x1A and wr_data=0xBEEF; loc_addr=0x1A gives loc_rdata=0xBEEF.
REQ-036 Following read, cmd 0x00D2 -> master samples 0xBEEF on MISO; no wr_valid.
REQ-037 Burst write, cmd 0x00FC + data 0xAAAA, 0xBBBB -> mem[31]=0xAAAA, mem[0]=0xBBBB; two wr_valid pulses.
- Then burst read, cmd 0x00FE over 2 words -> 0xAAAA, 0xBBBB.
REQ-038 Run the REQ-035/REQ-036 sequence in each of modes 1, 2 and 3 -> identical results.
REQ-039 CS deasserted after 9 data bits of a write to 0x05 -> no wr_valid, mem[5] unchanged (0); address 0x40 write -> ignored, read of 0x40 returns 0x0000.
REQ-040 rst asserted mid-read frame -> all outputs 0 immediately; a subsequent valid frame completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave register file:
// command layout, FSM states and SCLK sample-edge selection.
package spi_pkg;

  localparam int CMD_W     = 16;
  localparam int ADDR_HI   = 10;
  localparam int ADDR_LO   = 3;
  localparam int BURST_BIT = 2;
  localparam int READ_BIT  = 1;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  function automatic logic sample_rising(
    input int cpol,
    input int cpha
  );
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous input,
// with rise/fall pulses derived from the synchronised level.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave exposing a DEPTH x DATA_W register file,
// with single/burst read and write frames and a local read port.
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk_in,
  input  logic              spi_cs_n_in,
  input  logic              spi_mosi_in,
  output logic              spi_miso_out,
  output logic              spi_miso_oe,
  input  logic [7:0]        loc_addr,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              wr_valid,
  output logic [7:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int SH_W  = (DATA_W > CMD_W) ? DATA_W : CMD_W;
  localparam logic SAMPLE_RISE = sample_rising(CPOL, CPHA);

  logic sclk_s, sclk_r, sclk_f;
  logic cs_s, cs_r, cs_f;
  logic mosi_s, mosi_r, mosi_f;

  spi_sync_edge u_sclk (
    .clk(clk), .rst(rst), .async_in(spi_sclk_in),
    .sync(sclk_s), .rise(sclk_r), .fall(sclk_f)
  );

  spi_sync_edge u_cs (
    .clk(clk), .rst(rst), .async_in(spi_cs_n_in),
    .sync(cs_s), .rise(cs_r), .fall(cs_f)
  );

  spi_sync_edge u_mosi (
    .clk(clk), .rst(rst), .async_in(spi_mosi_in),
    .sync(mosi_s), .rise(mosi_r), .fall(mosi_f)
  );

  state_t            state;
  logic [5:0]        bit_cnt;
  logic [SH_W-1:0]   in_sh;
  logic [DATA_W-1:0] out_sh;
  logic [7:0]        addr;
  logic              burst;
  logic              rd;
  logic              done;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              sample;
  logic [CMD_W-1:0]  cmd_w;
  logic [DATA_W-1:0] word_w;
  logic [7:0]        next_addr;
  logic              unused_ok;

  assign sample    = SAMPLE_RISE ? sclk_r : sclk_f;
  assign cmd_w     = {in_sh[CMD_W-2:0], mosi_s};
  assign word_w    = {in_sh[DATA_W-2:0], mosi_s};
  assign next_addr = (int'(addr) == DEPTH - 1) ? 8'd0 : addr + 8'd1;
  assign unused_ok = ^{sclk_s, cs_s, mosi_r, mosi_f,
                       in_sh[SH_W-1], cmd_w};

  // Out-of-range addresses read as zero
  function automatic logic [DATA_W-1:0] rd_word(
    input logic [7:0] a
  );
    return (int'(a) < DEPTH) ? mem[a[IDX_W-1:0]] : '0;
  endfunction

  assign spi_miso_out = out_sh[DATA_W-1];
  assign spi_miso_oe  = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      in_sh     <= '0;
      out_sh    <= '0;
      addr      <= '0;
      burst     <= 1'b0;
      rd        <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      loc_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_valid  <= 1'b0;
      loc_rdata <= rd_word(loc_addr);
      if (cs_f) begin
        state   <= CMD;
        busy    <= 1'b1;
        bit_cnt <= '0;
        in_sh   <= '0;
        out_sh  <= '0;
        addr    <= '0;
        burst   <= 1'b0;
        rd      <= 1'b0;
        done    <= 1'b0;
      end else if (cs_r) begin
        state  <= IDLE;
        busy   <= 1'b0;
        out_sh <= '0;
      end else if (sample) begin
        unique case (state)
          CMD: begin
            in_sh <= {in_sh[SH_W-2:0], mosi_s};
            if (int'(bit_cnt) == CMD_W - 1) begin
              state   <= DATA;
              bit_cnt <= '0;
              addr    <= cmd_w[ADDR_HI:ADDR_LO];
              burst   <= cmd_w[BURST_BIT];
              rd      <= cmd_w[READ_BIT];
              if (cmd_w[READ_BIT])
                out_sh <= rd_word(cmd_w[ADDR_HI:ADDR_LO]);
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          DATA: begin
            if (!done) begin
              in_sh <= {in_sh[SH_W-2:0], mosi_s};
              if (int'(bit_cnt) == DATA_W - 1) begin
                bit_cnt <= '0;
                if (!rd && int'(addr) < DEPTH) begin
                  wr_valid <= 1'b1;
                  wr_addr  <= addr;
                  wr_data  <= word_w;
                  mem[addr[IDX_W-1:0]] <= word_w;
                end
                if (burst) begin
                  addr   <= next_addr;
                  out_sh <= rd ? rd_word(next_addr) : '0;
                end else begin
                  done   <= 1'b1;
                  out_sh <= '0;
                end
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
                out_sh  <= {out_sh[DATA_W-2:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
